la_capture_fifo: RTL and testbench
==================================

# la_capture_fifo

Capture front-end of the logic analyzer: samples the 32-bit probe bus at a programmable rate while capture is enabled and buffers the samples in an on-chip FIFO. Sits directly upstream of the FT601 transmit FSM.
- The FSM pops words with `fifo_pop_n` and reads `fifo_dout`.
- Its `full_fifo`/`empty_fifo` flags steer the FSM's write path.
- Tracks samples lost to overflow so the host can detect gaps.

## Interface
Parameters:
- `DATA_LEN`, 32: probe and FIFO word width.
- `ADDR_LEN`, 10: FIFO depth is 2^ADDR_LEN words.
- `DIV_LEN`, 16: sample-divider width.

Ports:
- `clk` input 1: single clock; all logic on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `run_en` input 1: capture enable from the command path; level-sensitive.
- `div` input DIV_LEN: sample period minus one, in clk cycles.
- `probe_in` input DATA_LEN: probe bus, already synchronized to `clk`.
- `fifo_pop_n` input 1: active-low pop, one word per cycle.
- `fifo_dout` output DATA_LEN: registered read data.
- `full_fifo` output 1: FIFO holds 2^ADDR_LEN words.
- `empty_fifo` output 1: FIFO holds 0 words.
- `level` output ADDR_LEN+1: current occupancy.
- `overflow` output 1: sticky; at least one sample dropped since the last flush.
- `drop_cnt` output 16: dropped-sample count, saturating at 16'hFFFF.
- `capturing` output 1: high in CAPTURE state.

## Operation
- States: IDLE, FLUSH, CAPTURE.
  - IDLE -> FLUSH when `run_en`=1.
  - FLUSH -> CAPTURE unconditionally after 1 cycle.
  - CAPTURE -> IDLE when `run_en`=0.
  - Any other encoding -> IDLE.
- FLUSH:
  - Clears read pointer, write pointer, `level`, `overflow` and `drop_cnt`; sets `fifo_dout` to 0.
  - Latches `div` into an internal period register.
  - Clears the divider counter to 0.
- CAPTURE, divider:
  - Sample tick when counter==0.
  - On a tick the counter reloads the latched period; otherwise it decrements.
  - Result: ticks occur in the first CAPTURE cycle and every period+1 cycles after that.
  - `div`=0 samples every cycle.
  - Changes to `div` during CAPTURE are ignored until the next FLUSH.
- Push on a tick:
  - If `full_fifo`=0: write `probe_in` at the write pointer; write pointer +1 (mod depth).
  - If `full_fifo`=1: discard the sample, set `overflow`, `drop_cnt`+1 saturating.
- Pop, in any state except FLUSH:
  - When `fifo_pop_n`=0 and `empty_fifo`=0: `fifo_dout` <= mem[read pointer]; read pointer +1 (mod depth).
  - Pop while empty is ignored; `fifo_dout` holds.
  - `fifo_dout` holds whenever no pop occurs.
- Draining: pops continue in IDLE, so the host can drain after STOP. Stored data survives IDLE and is only cleared by FLUSH.
- Full and empty are judged on the pre-edge `level`:
  - Push and pop in the same cycle while full: pop succeeds, push is dropped and counted.
  - Push and pop in the same cycle while empty: push succeeds, pop is ignored.
  - Push and pop in the same cycle otherwise: both succeed, `level` unchanged.
- `level` arithmetic: +1 on push-only, -1 on pop-only, never outside 0..2^ADDR_LEN.
- Flags: `full_fifo`=(`level`==2^ADDR_LEN), `empty_fifo`=(`level`==0). Both registered, consistent with `level`.

## Timing
- Reset values:
  - State IDLE.
  - `fifo_dout`=0, `empty_fifo`=1, `full_fifo`=0.
  - `level`=0, `overflow`=0, `drop_cnt`=0, `capturing`=0.
- Reset mid-capture discards all contents immediately (asynchronous).
- Capture start: `run_en` rises at edge N.
  - State is FLUSH after edge N+1 and CAPTURE after N+2.
  - First sample is written at edge N+3; `empty_fifo` falls after N+3.
- Read latency: pop asserted before edge K gives valid `fifo_dout` after edge K. The consumer latches it at the following edge.
- `run_en` low: CAPTURE -> IDLE at the next edge. No tick is taken in the IDLE cycle.
- `run_en` toggling 1-0-1 always passes through FLUSH; earlier data is lost.
- Pointers wrap silently at 2^ADDR_LEN. Occupancy is determined solely by `level`.

## Test plan
- Reset release, then `run_en`=1, `div`=0, `probe_in` counting 0,1,2…:
  - Words are written every cycle starting at edge N+3.
  - Popping 4 returns consecutive values starting with the value present at N+3.
- `div`=3, `probe_in` = cycle counter, 20 cycles of capture:
  - `level`=5.
  - Popped words differ by exactly 4.
- ADDR_LEN=4, `div`=0, no pops for 20 CAPTURE cycles:
  - `full_fifo`=1 after the 16th write.
  - `overflow`=1, `drop_cnt`=4.
  - Pops return the first 16 samples in order.
- Full FIFO with simultaneous push and pop:
  - `level` drops to 15.
  - `drop_cnt` +1.
  - `fifo_dout` = oldest word.
- `run_en`=0 mid-capture, then drain:
  - `capturing`=0 after 1 edge; no further writes.
  - All remaining words pop out, `empty_fifo`=1.
  - Extra pops leave `fifo_dout` unchanged.
- `rst` pulse asserted mid-capture with `level`=7:
  - Outputs go to reset values without waiting for a clock edge.
  - Restart via `run_en` captures cleanly.

Source files
------------

// File: rtl/la_capture_fifo.sv
// Logic-analyzer capture front-end: divides the clock into sample ticks while
// running and buffers probe samples in a block-RAM FIFO for the FT601 transmit FSM.
module la_capture_fifo #(
   parameter int DATA_LEN = 32,
   parameter int ADDR_LEN = 10,
   parameter int DIV_LEN  = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                run_en,
   input  logic [DIV_LEN-1:0]  div,
   input  logic [DATA_LEN-1:0] probe_in,
   input  logic                fifo_pop_n,
   output logic [DATA_LEN-1:0] fifo_dout,
   output logic                full_fifo,
   output logic                empty_fifo,
   output logic [ADDR_LEN:0]   level,
   output logic                overflow,
   output logic [15:0]         drop_cnt,
   output logic                capturing
);

   localparam int              DEPTH_INT = 1 << ADDR_LEN;
   localparam logic [ADDR_LEN:0] DEPTH   = {1'b1, {ADDR_LEN{1'b0}}};

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FLUSH   = 2'd1,
      CAPTURE = 2'd2
   } state_t;

   state_t state_reg, state_next;

   logic [DIV_LEN-1:0]  period_reg;
   logic [DIV_LEN-1:0]  cnt_reg;
   logic [ADDR_LEN-1:0] wr_ptr_reg;
   logic [ADDR_LEN-1:0] rd_ptr_reg;
   logic [ADDR_LEN:0]   level_reg, level_next;
   logic [DATA_LEN-1:0] dout_reg;
   logic                full_reg;
   logic                empty_reg;
   logic                overflow_reg;
   logic [15:0]         drop_cnt_reg;

   logic                flush;
   logic                tick;
   logic                push_ok;
   logic                drop;
   logic                pop_ok;

   logic [DATA_LEN-1:0] mem [0:DEPTH_INT-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = IDLE;
      flush      = 1'b0;
      tick       = 1'b0;
      case (state_reg)
         IDLE:    state_next = run_en ? FLUSH : IDLE;
         FLUSH: begin
            state_next = CAPTURE;
            flush      = 1'b1;
         end
         CAPTURE: begin
            state_next = run_en ? CAPTURE : IDLE;
            tick       = (cnt_reg == '0);
         end
         default: state_next = IDLE;
      endcase
   end

   // Full/empty come from the registered flags, i.e. the pre-edge occupancy.
   assign push_ok = tick & ~full_reg;
   assign drop    = tick &  full_reg;
   assign pop_ok  = ~flush & ~fifo_pop_n & ~empty_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         period_reg <= '0;
         cnt_reg    <= '0;
      end else if (flush) begin
         period_reg <= div;
         cnt_reg    <= '0;
      end else if (state_reg == CAPTURE) begin
         cnt_reg <= tick ? period_reg : cnt_reg - DIV_LEN'(1);
      end
   end

   // Storage array carries no reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr_reg] <= probe_in;
      end
   end

   always_comb begin
      level_next = level_reg;
      if (push_ok && !pop_ok) begin
         level_next = level_reg + (ADDR_LEN+1)'(1);
      end else if (pop_ok && !push_ok) begin
         level_next = level_reg - (ADDR_LEN+1)'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
         full_reg   <= 1'b0;
         empty_reg  <= 1'b1;
         dout_reg   <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
         full_reg   <= 1'b0;
         empty_reg  <= 1'b1;
         dout_reg   <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + ADDR_LEN'(1);
         end
         if (pop_ok) begin
            rd_ptr_reg <= rd_ptr_reg + ADDR_LEN'(1);
            dout_reg   <= mem[rd_ptr_reg];
         end
         level_reg <= level_next;
         full_reg  <= (level_next == DEPTH);
         empty_reg <= (level_next == '0);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_reg <= 1'b0;
         drop_cnt_reg <= '0;
      end else if (flush) begin
         overflow_reg <= 1'b0;
         drop_cnt_reg <= '0;
      end else if (drop) begin
         overflow_reg <= 1'b1;
         if (drop_cnt_reg != 16'hFFFF) begin
            drop_cnt_reg <= drop_cnt_reg + 16'd1;
         end
      end
   end

   assign fifo_dout  = dout_reg;
   assign full_fifo  = full_reg;
   assign empty_fifo = empty_reg;
   assign level      = level_reg;
   assign overflow   = overflow_reg;
   assign drop_cnt   = drop_cnt_reg;
   assign capturing  = (state_reg == CAPTURE);

endmodule

// File: tb/tb_la_capture_fifo.sv
// Self-checking bench for la_capture_fifo: directed scenarios plus randomized
// runs, all compared against a queue-based reference model.
module tb_la_capture_fifo;

   localparam int DATA_LEN = 32;
   localparam int ADDR_LEN = 4;
   localparam int DIV_LEN  = 16;
   localparam int DEPTH    = 1 << ADDR_LEN;

   logic                clk;
   logic                rst;
   logic                run_en;
   logic [DIV_LEN-1:0]  div;
   logic [DATA_LEN-1:0] probe_in;
   logic                fifo_pop_n;
   logic [DATA_LEN-1:0] fifo_dout;
   logic                full_fifo;
   logic                empty_fifo;
   logic [ADDR_LEN:0]   level;
   logic                overflow;
   logic [15:0]         drop_cnt;
   logic                capturing;

   la_capture_fifo #(
      .DATA_LEN (DATA_LEN),
      .ADDR_LEN (ADDR_LEN),
      .DIV_LEN  (DIV_LEN)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .run_en     (run_en),
      .div        (div),
      .probe_in   (probe_in),
      .fifo_pop_n (fifo_pop_n),
      .fifo_dout  (fifo_dout),
      .full_fifo  (full_fifo),
      .empty_fifo (empty_fifo),
      .level      (level),
      .overflow   (overflow),
      .drop_cnt   (drop_cnt),
      .capturing  (capturing)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference model: mode 0 idle, 1 flush, 2 capture.
   int                  m_mode;
   logic [DATA_LEN-1:0] m_q[$];
   logic [DATA_LEN-1:0] m_dout;
   bit                  m_ovf;
   int                  m_drop;
   int                  m_period;
   int                  m_cyc;
   int unsigned         cyc_ctr;

   task automatic model_reset();
      m_mode   = 0;
      m_q.delete();
      m_dout   = '0;
      m_ovf    = 1'b0;
      m_drop   = 0;
      m_period = 0;
      m_cyc    = 0;
   endtask

   task automatic model_edge();
      bit was_full  = (m_q.size() == DEPTH);
      bit was_empty = (m_q.size() == 0);
      bit tick      = 1'b0;
      if (m_mode == 1) begin
         m_q.delete();
         m_dout   = '0;
         m_ovf    = 1'b0;
         m_drop   = 0;
         m_period = int'(div);
         m_cyc    = 0;
      end else if (m_mode == 2) begin
         tick  = ((m_cyc % (m_period + 1)) == 0);
         m_cyc = m_cyc + 1;
      end
      if (m_mode != 1 && !fifo_pop_n && !was_empty) begin
         m_dout = m_q.pop_front();
      end
      if (tick) begin
         if (was_full) begin
            m_ovf = 1'b1;
            if (m_drop < 65535) m_drop++;
         end else begin
            m_q.push_back(probe_in);
         end
      end
      case (m_mode)
         0:       m_mode = run_en ? 1 : 0;
         1:       m_mode = 2;
         default: m_mode = run_en ? 2 : 0;
      endcase
   endtask

   task automatic compare_all();
      check("dout",      fifo_dout,  m_dout);
      check("full",      full_fifo,  m_q.size() == DEPTH);
      check("empty",     empty_fifo, m_q.size() == 0);
      check("level",     level,      m_q.size());
      check("overflow",  overflow,   m_ovf);
      check("drop_cnt",  drop_cnt,   m_drop);
      check("capturing", capturing,  m_mode == 2);
   endtask

   // One clock with probe_in set to the running cycle counter.
   task automatic step();
      probe_in = cyc_ctr;
      cyc_ctr++;
      model_edge();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic step_rand();
      probe_in = $urandom;
      model_edge();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   int unsigned base;
   logic [DATA_LEN-1:0] popped[$];

   initial begin
      rst        = 1'b1;
      run_en     = 1'b0;
      div        = '0;
      probe_in   = '0;
      fifo_pop_n = 1'b1;
      cyc_ctr    = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_dout",  fifo_dout,  0);
      check("rst_empty", empty_fifo, 1);
      check("rst_full",  full_fifo,  0);
      check("rst_level", level,      0);
      check("rst_ovf",   overflow,   0);
      check("rst_drop",  drop_cnt,   0);
      check("rst_cap",   capturing,  0);
      rst = 1'b0;

      // div=0, consecutive samples, pop four while still capturing
      base   = cyc_ctr;
      run_en = 1'b1;
      div    = 0;
      repeat (2) step();
      check("first_empty_before", empty_fifo, 1);
      step();
      check("first_empty_after", empty_fifo, 0);
      repeat (7) step();
      fifo_pop_n = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         check("pop4", fifo_dout, base + 2 + k);
      end
      run_en = 1'b0;
      repeat (2) step();
      check("stop_cap", capturing, 0);
      repeat (28) step();
      check("drain_empty", empty_fifo, 1);
      check("drain_last", fifo_dout, base + 14);
      fifo_pop_n = 1'b1;
      $display("phase div0: last word %0d", fifo_dout);

      // div=3 for 20 capture cycles, then drain
      run_en = 1'b1;
      div    = 3;
      repeat (21) step();
      run_en = 1'b0;
      step();
      check("div3_level", level, 5);
      check("div3_cap", capturing, 0);
      popped.delete();
      fifo_pop_n = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         popped.push_back(fifo_dout);
      end
      fifo_pop_n = 1'b1;
      step();
      for (int k = 1; k < 5; k++) begin
         check("div3_delta", popped[k] - popped[k-1], 4);
      end
      $display("phase div3: popped %0d words", popped.size());

      // fill past full with div=0, then push+pop while full, then drain
      base   = cyc_ctr;
      run_en = 1'b1;
      div    = 0;
      repeat (22) step();
      check("full_flag", full_fifo, 1);
      check("full_level", level, 16);
      check("full_ovf", overflow, 1);
      check("full_drop", drop_cnt, 4);
      fifo_pop_n = 1'b0;
      run_en     = 1'b0;
      step();
      check("fullpp_level", level, 15);
      check("fullpp_drop", drop_cnt, 5);
      check("fullpp_dout", fifo_dout, base + 2);
      for (int k = 0; k < 15; k++) begin
         step();
         check("full_order", fifo_dout, base + 3 + k);
      end
      repeat (3) step();
      check("extra_pop_dout", fifo_dout, base + 17);
      check("extra_pop_empty", empty_fifo, 1);
      fifo_pop_n = 1'b1;
      $display("phase full: drop_cnt %0d", drop_cnt);

      // asynchronous reset with level 7
      run_en = 1'b1;
      div    = 0;
      repeat (9) step();
      check("pre_rst_level", level, 7);
      run_en = 1'b0;
      #3;
      rst = 1'b1;
      #1;
      model_reset();
      compare_all();
      @(posedge clk);
      #2;
      rst = 1'b0;
      run_en = 1'b1;
      repeat (12) step();
      run_en = 1'b0;
      fifo_pop_n = 1'b0;
      repeat (14) step();
      fifo_pop_n = 1'b1;
      $display("phase reset: restart level %0d", level);

      // randomized runs, including 1-0-1 toggles and mid-run div changes
      for (int r = 0; r < 8; r++) begin
         int pop_pct = $urandom_range(10, 90);
         div    = DIV_LEN'($urandom_range(0, 4));
         run_en = 1'b1;
         for (int c = 0; c < int'($urandom_range(20, 60)); c++) begin
            fifo_pop_n = ($urandom_range(0, 99) >= pop_pct);
            if ($urandom_range(0, 29) == 0) run_en = ~run_en;
            else run_en = 1'b1;
            if ($urandom_range(0, 15) == 0) div = DIV_LEN'($urandom_range(0, 4));
            step_rand();
         end
         run_en = 1'b0;
         for (int c = 0; c < 24; c++) begin
            fifo_pop_n = ($urandom_range(0, 3) == 0);
            step_rand();
         end
         $display("phase random %0d: level %0d drop_cnt %0d", r, level, drop_cnt);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
